// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-cycle WIDTH-bit adder controller: streams nibble pairs through an external
// combinational 4-bit full adder, chaining the carry, with valid/ready on both sides.
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             carry;
  logic [IW-1:0]    idx;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_a     = 4'h0;
    add_b     = 4'h0;
    add_cin   = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        add_a   = a_reg[4*idx +: 4];
        add_b   = b_reg[4*idx +: 4];
        add_cin = carry;
        if (idx == LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result registers only change on acceptance (clear) and while RUN (fill),
  // so a finished result stays readable after the consumer takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg   <= in_a;
            b_reg   <= in_b;
            carry   <= in_cin;
            idx     <= '0;
            out_sum <= '0;
          end
        end
        RUN: begin
          out_sum[4*idx +: 4] <= add_sum;
          carry               <= add_cout;
          if (idx == LAST) begin
            idx      <= '0;
            out_cout <= add_cout;
            out_ovf  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (add_sum[3] != a_reg[WIDTH-1]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench: behavioural adder plus a plain-arithmetic reference for sums,
// per-nibble carries and signed overflow; stimulus on negedge, sampling on negedge.
module tb_nibble_serial_adder_ctrl;
  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n, in_valid, in_ready, in_cin;
  logic [WIDTH-1:0] in_a, in_b, out_sum;
  logic [3:0]       add_a, add_b, add_sum;
  logic             add_cin, add_cout;
  logic             out_valid, out_ready, out_cout, out_ovf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  // Expected carry entering nibble k: carry out of the low 4k bits of a+b+cin.
  function automatic logic carry_into(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                      input logic cin, input int k);
    longint m, s;
    m = (64'd1 << (4 * k)) - 1;
    s = (longint'(a) & m) + (longint'(b) & m) + longint'(cin);
    return s[4*k];
  endfunction

  // Present operands at a negedge and let the next posedge accept them.
  task automatic drive_accept(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic cin, input string name);
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL %s in_ready_before_accept got=%b want=1", name, in_ready);
    end
    @(negedge clk);
  endtask

  // Walk the NIB RUN cycles, then check the DONE result. During RUN, in_valid/in_a/in_b
  // are driven with the given noise values, which must be ignored.
  task automatic check_run(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                           input logic nv, input logic [WIDTH-1:0] na, input logic [WIDTH-1:0] nb,
                           input string name);
    logic [WIDTH:0] exp;
    logic           ovf;
    exp = (WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(cin);
    ovf = (a[WIDTH-1] == b[WIDTH-1]) && (exp[WIDTH-1] != a[WIDTH-1]);
    in_valid = nv; in_a = na; in_b = nb; in_cin = 1'b1;
    for (int k = 0; k < NIB; k++) begin
      checks++;
      if (add_a !== a[4*k +: 4] || add_b !== b[4*k +: 4] || add_cin !== carry_into(a, b, cin, k)) begin
        errors++;
        $display("FAIL %s nibble%0d got a=%h b=%h cin=%b want a=%h b=%h cin=%b", name, k,
                 add_a, add_b, add_cin, a[4*k +: 4], b[4*k +: 4], carry_into(a, b, cin, k));
      end
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
        errors++; $display("FAIL %s run_flags%0d got valid=%b ready=%b want 0 0", name, k, out_valid, in_ready);
      end
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL %s done_flags got valid=%b ready=%b want 1 0", name, out_valid, in_ready);
    end
    checks++;
    if (out_sum !== exp[WIDTH-1:0] || out_cout !== exp[WIDTH] || out_ovf !== ovf) begin
      errors++;
      $display("FAIL %s result got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b", name,
               out_sum, out_cout, out_ovf, exp[WIDTH-1:0], exp[WIDTH], ovf);
    end
    checks++;
    if (add_a !== 4'h0 || add_b !== 4'h0 || add_cin !== 1'b0) begin
      errors++; $display("FAIL %s done_adder_idle got a=%h b=%h cin=%b want 0", name, add_a, add_b, add_cin);
    end
  endtask

  // Consumer takes the result; the result registers must hold afterwards.
  task automatic accept_result(input logic keep_valid, input string name);
    logic [WIDTH-1:0] s;
    logic             c, o;
    s = out_sum; c = out_cout; o = out_ovf;
    if (!keep_valid) in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== s || out_cout !== c || out_ovf !== o) begin
      errors++;
      $display("FAIL %s after_accept got valid=%b ready=%b sum=%h want 0 1 %h", name,
               out_valid, in_ready, out_sum, s);
    end
  endtask

  task automatic do_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                        input string name);
    drive_accept(a, b, cin, name);
    check_run(a, b, cin, 1'b0, '0, '0, name);
    accept_result(1'b0, name);
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== '0 || out_cout !== 1'b0 ||
        out_ovf !== 1'b0 || add_a !== 4'h0 || add_b !== 4'h0 || add_cin !== 1'b0) begin
      errors++;
      $display("FAIL %s reset_vals got rdy=%b vld=%b sum=%h cout=%b ovf=%b a=%h b=%h cin=%b", name,
               in_ready, out_valid, out_sum, out_cout, out_ovf, add_a, add_b, add_cin);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("reset_release");
  endtask

  task automatic test_basic();
    do_add(16'h1234, 16'h4321, 1'b0, "basic");
  endtask

  task automatic test_ripple();
    do_add(16'hFFFF, 16'h0000, 1'b1, "ripple");
  endtask

  task automatic test_overflow();
    do_add(16'h7FFF, 16'h0001, 1'b0, "ovf_pos");
    do_add(16'h8000, 16'h8000, 1'b0, "ovf_neg");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      do_add(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(1)), "random");
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] s;
    drive_accept(16'h2468, 16'h1357, 1'b0, "bp");
    check_run(16'h2468, 16'h1357, 1'b0, 1'b1, 16'h1111, 16'h1111, "bp");
    s = out_sum;
    for (int i = 0; i < 6; i++) begin
      in_valid = (i % 2 == 0);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== s) begin
        errors++;
        $display("FAIL bp hold%0d got valid=%b ready=%b sum=%h want 1 0 %h", i, out_valid, in_ready, out_sum, s);
      end
    end
    accept_result(1'b0, "bp");
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || add_a !== 4'h0) begin
      errors++; $display("FAIL bp idle_after got valid=%b ready=%b add_a=%h want 0 1 0", out_valid, in_ready, add_a);
    end
  endtask

  task automatic test_back_to_back();
    drive_accept(16'h0001, 16'h0001, 1'b0, "b2b1");
    check_run(16'h0001, 16'h0001, 1'b0, 1'b1, 16'hABCD, 16'h1111, "b2b1");
    in_cin = 1'b0;
    accept_result(1'b1, "b2b1");
    @(negedge clk);
    check_run(16'hABCD, 16'h1111, 1'b0, 1'b0, '0, '0, "b2b2");
    accept_result(1'b0, "b2b2");
  endtask

  task automatic test_reset_mid_run();
    drive_accept(16'h5555, 16'h5555, 1'b1, "rst_mid");
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("rst_mid");
    rst_n = 1'b1;
    for (int i = 0; i < NIB + 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL rst_mid aborted%0d got valid=%b ready=%b want 0 1", i, out_valid, in_ready);
      end
    end
    do_add(16'h0F0F, 16'h00F1, 1'b0, "rst_after");
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_ripple();
    test_overflow();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
